// File: rtl/prom_boot_sequencer.sv
// Boot PROM reader: assembles BYTES_PER_WORD bytes (LSB first) into microwords and hands them
// downstream over valid/ready. Define PROM_BOOT_CHECKSUM_EN to add a trailing checksum byte check.
module prom_boot_sequencer #(
    parameter int unsigned BYTES_PER_WORD = 6,
    parameter int unsigned N_WORDS        = 85,
    parameter int unsigned WAIT_CYCLES    = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    output logic [8:0]                    prom_a,
    output logic                          prom_ce_n,
    input  logic [7:0]                    prom_d,
    output logic [8*BYTES_PER_WORD-1:0]   word_data,
    output logic [6:0]                    word_addr,
    output logic                          word_valid,
    input  logic                          word_ready,
`ifdef PROM_BOOT_CHECKSUM_EN
    output logic                          csum_err,
`endif
    output logic                          busy,
    output logic                          done
);
    localparam int unsigned   KW        = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [KW-1:0] LAST_K    = KW'(BYTES_PER_WORD - 1);
    localparam logic [6:0]    LAST_W    = 7'(N_WORDS - 1);
    localparam logic [3:0]    LAST_WAIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic [3:0]    wait_cnt;
    logic          capture;
`ifdef PROM_BOOT_CHECKSUM_EN
    logic [7:0]    sum;
    logic          csum_phase;
`endif

    // prom_d is sampled on the edge that ends the last settle cycle of a byte fetch
    assign capture = ((state == FETCH) && (WAIT_CYCLES == 0)) ||
                     ((state == WAIT) && (wait_cnt == LAST_WAIT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            prom_a     <= '0;
            prom_ce_n  <= 1'b1;
            word_data  <= '0;
            word_addr  <= '0;
            word_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            k          <= '0;
            wait_cnt   <= '0;
`ifdef PROM_BOOT_CHECKSUM_EN
            sum        <= '0;
            csum_phase <= 1'b0;
            csum_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= FETCH;
                        prom_a    <= '0;
                        word_addr <= '0;
                        k         <= '0;
                        prom_ce_n <= 1'b0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
`ifdef PROM_BOOT_CHECKSUM_EN
                        sum        <= '0;
                        csum_phase <= 1'b0;
                        csum_err   <= 1'b0;
`endif
                    end
                end
                FETCH: begin
                    wait_cnt <= '0;
                    if (WAIT_CYCLES != 0) state <= WAIT;
                end
                WAIT: wait_cnt <= wait_cnt + 4'd1;
                EMIT: begin
                    if (word_ready) begin
                        word_valid <= 1'b0;
                        if (word_addr == LAST_W) begin
`ifdef PROM_BOOT_CHECKSUM_EN
                            csum_phase <= 1'b1;
                            prom_ce_n  <= 1'b0;
                            state      <= FETCH;
`else
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
`endif
                        end else begin
                            word_addr <= word_addr + 7'd1;
                            k         <= '0;
                            prom_ce_n <= 1'b0;
                            state     <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Capture overrides the FETCH/WAIT next-state chosen above
            if (capture) begin
                prom_a <= prom_a + 9'd1;
`ifdef PROM_BOOT_CHECKSUM_EN
                sum <= sum + prom_d;
                if (csum_phase) begin
                    csum_err  <= (sum + prom_d) != 8'd0;
                    prom_ce_n <= 1'b1;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= DONE;
                end else begin
`else
                begin
`endif
                    word_data[8*int'(k) +: 8] <= prom_d;
                    if (k == LAST_K) begin
                        prom_ce_n  <= 1'b1;
                        word_valid <= 1'b1;
                        state      <= EMIT;
                    end else begin
                        k     <= k + 1'b1;
                        state <= FETCH;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_prom_boot_sequencer.sv
// Scoreboard bench for prom_boot_sequencer: three instances (WAIT_CYCLES 1, 0, 3) on an
// address-pattern PROM model; expected words are queued at start and popped on handshake.
`timescale 1ns/1ps
module tb_prom_boot_sequencer;
    localparam int unsigned BPW = 6;
    localparam int unsigned NW  = 2;
    localparam int          NI  = 3;
`ifdef PROM_BOOT_CHECKSUM_EN
    localparam logic [8:0]  FINAL_A = 9'(NW*BPW + 1);
`else
    localparam logic [8:0]  FINAL_A = 9'(NW*BPW);
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start     [NI];
    logic        ready     [NI];
    logic [8:0]  prom_a    [NI];
    logic        ce_n      [NI];
    logic [7:0]  prom_d    [NI];
    logic [47:0] word_data [NI];
    logic [6:0]  word_addr [NI];
    logic        valid     [NI];
    logic        busy      [NI];
    logic        done      [NI];
`ifdef PROM_BOOT_CHECKSUM_EN
    logic        csum_err  [NI];
    logic [7:0]  csum_byte;
`endif
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int unsigned W = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        logic [54:0] exp_q[$];
        int ce_low = 0;

        prom_boot_sequencer #(
            .BYTES_PER_WORD(BPW),
            .N_WORDS(NW),
            .WAIT_CYCLES(W)
        ) u_dut (
            .clk(clk),
            .reset_n(reset_n),
            .start(start[g]),
            .prom_a(prom_a[g]),
            .prom_ce_n(ce_n[g]),
            .prom_d(prom_d[g]),
            .word_data(word_data[g]),
            .word_addr(word_addr[g]),
            .word_valid(valid[g]),
            .word_ready(ready[g]),
`ifdef PROM_BOOT_CHECKSUM_EN
            .csum_err(csum_err[g]),
`endif
            .busy(busy[g]),
            .done(done[g])
        );

`ifdef PROM_BOOT_CHECKSUM_EN
        assign prom_d[g] = (prom_a[g] == 9'(NW*BPW)) ? csum_byte : prom_a[g][7:0];
`else
        assign prom_d[g] = prom_a[g][7:0];
`endif

        always @(negedge clk or negedge reset_n) begin
            if (!reset_n) begin
                exp_q.delete();
                ce_low = 0;
            end else begin
                if (start[g] && !busy[g]) begin
                    logic [47:0] d;
                    check($sformatf("leftover%0d", g), 64'(exp_q.size()), 64'd0);
                    for (int w = 0; w < int'(NW); w++) begin
                        for (int b = 0; b < int'(BPW); b++) d[8*b +: 8] = 8'(w*int'(BPW) + b);
                        exp_q.push_back({7'(w), d});
                    end
                end
                if (valid[g]) begin
                    check($sformatf("emit_ce%0d", g), 64'(ce_n[g]), 64'd1);
                    if (exp_q.size() == 0) begin
                        check($sformatf("unexpected_word%0d", g), 64'd1, 64'd0);
                    end else begin
                        check($sformatf("data%0d", g), 64'(word_data[g]), 64'(exp_q[0][47:0]));
                        check($sformatf("waddr%0d", g), 64'(word_addr[g]), 64'(exp_q[0][54:48]));
                        if (ready[g]) void'(exp_q.pop_front());
                    end
                end
                if (!ce_n[g]) begin
                    ce_low++;
                end else if (ce_low != 0) begin
                    int unsigned exp_len;
                    exp_len = BPW*(1+W);
`ifdef PROM_BOOT_CHECKSUM_EN
                    if (prom_a[g] == 9'(NW*BPW + 1)) exp_len = 1 + W;
`endif
                    check($sformatf("ce_low%0d", g), 64'(ce_low), 64'(exp_len));
                    ce_low = 0;
                end
            end
        end
    end

    task automatic pulse_start(input int g);
        @(posedge clk); #1 start[g] = 1'b1;
        @(posedge clk); #1 start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int budget);
        int n = 0;
        @(negedge clk);
        while (!done[g] && n < budget) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("done%0d", g), 64'(done[g]), 64'd1);
        check($sformatf("busy_end%0d", g), 64'(busy[g]), 64'd0);
        check($sformatf("final_a%0d", g), 64'(prom_a[g]), 64'(FINAL_A));
        check($sformatf("ce_end%0d", g), 64'(ce_n[g]), 64'd1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < NI; i++) begin
            start[i] = 1'b0;
            ready[i] = 1'b1;
        end
`ifdef PROM_BOOT_CHECKSUM_EN
        csum_byte = 8'hBE;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_a", 64'(prom_a[0]), 64'd0);
        check("rst_ce", 64'(ce_n[0]), 64'd1);
        check("rst_valid", 64'(valid[0]), 64'd0);
        check("rst_busy", 64'(busy[0]), 64'd0);
        check("rst_done", 64'(done[0]), 64'd0);
        check("rst_waddr", 64'(word_addr[0]), 64'd0);
        check("rst_wdata", 64'(word_data[0]), 64'd0);
        reset_n = 1'b1;

        // reset asserted mid-fetch of byte 3
        pulse_start(0);
        n = 0;
        while (!(prom_a[0] == 9'd3 && !ce_n[0]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reach_byte3", 64'(prom_a[0]), 64'd3);
        #2 reset_n = 1'b0;
        #1;
        check("async_ce", 64'(ce_n[0]), 64'd1);
        check("async_busy", 64'(busy[0]), 64'd0);
        check("async_valid", 64'(valid[0]), 64'd0);
        check("async_a", 64'(prom_a[0]), 64'd0);
        @(posedge clk); #1 reset_n = 1'b1;

        pulse_start(0);
        wait_done(0, 200);

        // backpressure, started from DONE
        ready[0] = 1'b0;
        pulse_start(0);
        check("restart_done", 64'(done[0]), 64'd0);
        check("restart_busy", 64'(busy[0]), 64'd1);
        check("restart_a", 64'(prom_a[0]), 64'd0);
        n = 0;
        while (!valid[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_seen", 64'(valid[0]), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 64'(valid[0]), 64'd1);
            check("stall_a", 64'(prom_a[0]), 64'd6);
            check("stall_waddr", 64'(word_addr[0]), 64'd0);
        end
        @(posedge clk); #1 ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("resume_valid", 64'(valid[0]), 64'd0);
        check("resume_ce", 64'(ce_n[0]), 64'd0);
        check("resume_a", 64'(prom_a[0]), 64'd6);
        check("resume_waddr", 64'(word_addr[0]), 64'd1);
        wait_done(0, 200);

        // start while busy must not disturb the run
        pulse_start(0);
        repeat (4) @(posedge clk);
        pulse_start(0);
        check("ign_busy", 64'(busy[0]), 64'd1);
        check("ign_a", 64'(prom_a[0]), 64'd3);
        wait_done(0, 200);

        // WAIT_CYCLES = 0 and 3 instances
        @(posedge clk); #1 start[1] = 1'b1; start[2] = 1'b1;
        @(posedge clk); #1 start[1] = 1'b0; start[2] = 1'b0;
        wait_done(1, 300);
        wait_done(2, 300);

`ifdef PROM_BOOT_CHECKSUM_EN
        check("csum_ok", 64'(csum_err[0]), 64'd0);
        csum_byte = 8'h00;
        pulse_start(0);
        wait_done(0, 200);
        check("csum_bad", 64'(csum_err[0]), 64'd1);
`endif

        check("q_empty0", 64'(g_inst[0].exp_q.size()), 64'd0);
        check("q_empty1", 64'(g_inst[1].exp_q.size()), 64'd0);
        check("q_empty2", 64'(g_inst[2].exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
